// File: rtl/controlador_ordenamiento.sv
// ---------------------------------------------------------------------------
// controlador_ordenamiento
//   Block sorting controller for 32-bit sign-magnitude fixed-point words
//   (bit 31 sign, [30:10] integer, [9:0] fraction). Collects N words from a
//   producer, bubble-sorts them ascending with a single comparator (one
//   compare/swap step per clock), then streams them to a consumer.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : producer has a word on in_data
//   in_ready   : block accepts a word this cycle (LOAD state)
//   in_data    : sign-magnitude input word
//   out_valid  : out_data holds a valid sorted word (OUT state)
//   out_ready  : consumer accepts out_data this cycle
//   out_data   : sorted word, ascending order
//   busy       : high while sorting
//
// Also contains comparador, the combinational sign-magnitude comparator
// used by the sort engine.
// ---------------------------------------------------------------------------

// Sign-magnitude comparator: exactly one of lt/gt/eq is high; -0 equals +0.
module comparador (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt,
    output logic        gt,
    output logic        eq
);

    logic [30:0] mag_a;
    logic [30:0] mag_b;

    assign mag_a = a[30:0];
    assign mag_b = b[30:0];

    always_comb begin
        lt = 1'b0;
        gt = 1'b0;
        eq = 1'b0;
        if (mag_a == 31'd0 && mag_b == 31'd0) begin
            // Both zero regardless of sign bit.
            eq = 1'b1;
        end else if (a[31] != b[31]) begin
            // Differing signs with at least one nonzero: negative side is smaller.
            lt = a[31];
            gt = b[31];
        end else if (mag_a == mag_b) begin
            eq = 1'b1;
        end else if ((mag_a < mag_b) ^ a[31]) begin
            // For two negatives the magnitude order is reversed.
            lt = 1'b1;
        end else begin
            gt = 1'b1;
        end
    end

endmodule

module controlador_ordenamiento #(
    parameter int unsigned N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int unsigned IW = $clog2(N);
    localparam logic [IW-1:0] LAST_W = IW'(N - 1);
    localparam logic [IW-1:0] LAST_I = IW'(N - 2);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_SORT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [31:0]   mem [N];
    logic [IW-1:0] wr;
    logic [IW-1:0] rd;
    logic [IW-1:0] cmp_idx;
    logic [IW-1:0] pass;
    logic          swapped;

    logic [31:0]   cmp_a;
    logic [31:0]   cmp_b;
    logic          cmp_lt;
    logic          cmp_gt;
    logic          cmp_eq;

    logic          load_last;
    logic          pass_end;
    logic          sort_done;
    logic          out_last;

    // Single comparator looking at the adjacent pair under the compare pointer.
    assign cmp_a = mem[cmp_idx];
    assign cmp_b = mem[cmp_idx + IW'(1)];

    comparador u_comparador (
        .a  (cmp_a),
        .b  (cmp_b),
        .lt (cmp_lt),
        .gt (cmp_gt),
        .eq (cmp_eq)
    );

    // Transition qualifiers shared by the FSM and the datapath.
    assign load_last = (state == S_LOAD) && in_valid && (wr == LAST_W);
    assign pass_end  = (state == S_SORT) && (cmp_idx == LAST_I);
    // Early exit when a whole pass (including this step) saw no swap, or the
    // worst-case N-1 passes are complete.
    assign sort_done = pass_end && ((!swapped && !cmp_gt) || (pass == LAST_I));
    assign out_last  = (state == S_OUT) && out_ready && (rd == LAST_W);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LOAD: if (load_last) state_nxt = S_SORT;
            S_SORT: if (sort_done) state_nxt = S_OUT;
            S_OUT:  if (out_last)  state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
    end

    // Output decode; out_data is forced to zero outside the OUT state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        unique case (state)
            S_LOAD: in_ready = 1'b1;
            S_SORT: busy     = 1'b1;
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = mem[rd];
            end
            default: ;
        endcase
    end

    // Buffer, pointers and pass bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr      <= '0;
            rd      <= '0;
            cmp_idx <= '0;
            pass    <= '0;
            swapped <= 1'b0;
            for (int k = 0; k < int'(N); k++) begin
                mem[k] <= '0;
            end
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        mem[wr] <= in_data;
                        wr      <= (wr == LAST_W) ? '0 : wr + IW'(1);
                    end
                end
                S_SORT: begin
                    // Strictly-greater swap only, which keeps equal words in order.
                    if (cmp_gt) begin
                        mem[cmp_idx]          <= cmp_b;
                        mem[cmp_idx + IW'(1)] <= cmp_a;
                    end
                    if (pass_end) begin
                        cmp_idx <= '0;
                        swapped <= 1'b0;
                        pass    <= sort_done ? '0 : pass + IW'(1);
                        if (sort_done) begin
                            rd <= '0;
                        end
                    end else begin
                        cmp_idx <= cmp_idx + IW'(1);
                        if (cmp_gt) begin
                            swapped <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        rd <= (rd == LAST_W) ? '0 : rd + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The comparator must always produce exactly one relation.
    always_ff @(posedge clk) begin
        if (rst_n && state == S_SORT) begin
            assert ($onehot({cmp_lt, cmp_gt, cmp_eq}));
        end
    end

endmodule

// File: tb/tb_controlador_ordenamiento.sv
module tb_controlador_ordenamiento;

    localparam int N = 8;
    typedef logic [31:0] blk_t [N];

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    controlador_ordenamiento #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endfunction

    // Numeric value of a sign-magnitude word, scaled by 1024.
    function automatic longint sm_val(input logic [31:0] w);
        longint m;
        m = longint'(w[30:0]);
        return w[31] ? -m : m;
    endfunction

    // Stable ascending sort by numeric value (insertion sort).
    function automatic void model_sort(input blk_t a, output blk_t r);
        logic [31:0] key;
        int j;
        r = a;
        for (int i = 1; i < N; i++) begin
            key = r[i];
            j = i - 1;
            while (j >= 0 && sm_val(r[j]) > sm_val(key)) begin
                r[j + 1] = r[j];
                j--;
            end
            r[j + 1] = key;
        end
    endfunction

    // Early-exit bubble sort runs (max leftward displacement + 1) passes,
    // capped at N-1, each pass taking N-1 cycles.
    function automatic int model_busy(input blk_t a);
        int k;
        int c;
        int p;
        k = 0;
        for (int i = 0; i < N; i++) begin
            c = 0;
            for (int j = 0; j < i; j++) begin
                if (sm_val(a[j]) > sm_val(a[i])) c++;
            end
            if (c > k) k = c;
        end
        p = (k + 1 < N - 1) ? k + 1 : N - 1;
        return p * (N - 1);
    endfunction

    blk_t exp_out;
    int   exp_busy = 0;
    int   blk_id = 0;

    // Compare process state.
    int          idx = 0;
    int          cur_blk = -1;
    int          busy_cnt = 0;
    bit          busy_checked = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (blk_id != cur_blk) begin
            cur_blk      = blk_id;
            idx          = 0;
            busy_cnt     = 0;
            busy_checked = 0;
        end
        if (rst_n) begin
            chk("ready_valid_exclusive", 32'(in_ready & out_valid), 32'd0);
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, prev_data);
            end
            if (busy) busy_cnt++;
            if (out_valid) begin
                if (!busy_checked) begin
                    chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
                    busy_checked = 1;
                end
                if (idx < N) chk("out_data", out_data, exp_out[idx]);
                else         chk("extra_word", 32'(idx), 32'(N - 1));
                chk("busy_in_out", 32'(busy), 32'd0);
                if (out_ready) idx++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end else begin
            prev_hold = 0;
        end
    end

    task automatic load_block(input blk_t w, input bit dead);
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = w[k];
            @(negedge clk);
            chk("in_ready_load", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = dead;
        in_data  = dead ? 32'hDEAD : 32'h0;
    endtask

    // mode 0: random out_ready; 1: 3-cycle stall after 2nd word; 2: random + in_valid held.
    task automatic drain(input int mode);
        int stall;
        bit done;
        stall = 0;
        done  = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (mode == 1) begin
                if (idx >= 2 && stall < 3 && out_valid) begin
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk); #1;
            if (mode == 2) chk("in_ready_t6", 32'(in_ready), 32'd0);
            if (idx >= N) done = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("drain_complete", 32'(idx), 32'(N));
        if (mode == 1) chk("t4_stalls", 32'(stall), 32'd3);
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_out_in_ready", 32'(in_ready), 32'd1);
        chk("post_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_block(input blk_t w, input int mode);
        model_sort(w, exp_out);
        exp_busy = model_busy(w);
        blk_id++;
        load_block(w, mode == 2);
        drain(mode);
    endtask

    blk_t t1, t2, t3, t3_exp, rnd, tmp;
    logic [31:0] pool [5];

    initial begin
        t1     = '{32'h0, 32'h200, 32'h400, 32'h600, 32'h800, 32'hA00, 32'hC00, 32'hE00};
        t2     = '{32'h1C00, 32'h1800, 32'h1400, 32'h1000, 32'hC00, 32'h800, 32'h400, 32'h0};
        t3     = '{32'h400, 32'h80000400, 32'h200, 32'h80000000,
                   32'h0, 32'hA8D99763, 32'h5E6D23E4, 32'h80000200};
        t3_exp = '{32'hA8D99763, 32'h80000400, 32'h80000200, 32'h80000000,
                   32'h0, 32'h200, 32'h400, 32'h5E6D23E4};
        pool   = '{32'h0, 32'h80000000, 32'h400, 32'h80000400, 32'h200};

        // Pin the model with hand-computed expectations.
        model_sort(t3, tmp);
        for (int k = 0; k < N; k++) chk("model_t3", tmp[k], t3_exp[k]);
        chk("model_busy_t1", 32'(model_busy(t1)), 32'd7);
        chk("model_busy_t2", 32'(model_busy(t2)), 32'd49);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        @(posedge clk); #1;

        run_block(t1, 0);   // T1
        run_block(t2, 0);   // T2
        run_block(t3, 0);   // T3
        run_block(t2, 1);   // T4
        run_block(t3, 2);   // T6

        // T5: reset after 10 sort cycles.
        begin
            int bc;
            model_sort(t2, exp_out);
            exp_busy = model_busy(t2);
            blk_id++;
            load_block(t2, 1'b0);
            bc = 0;
            for (int c = 0; c < 100 && bc < 10; c++) begin
                @(negedge clk);
                if (busy) bc++;
            end
            chk("t5_busy_seen", 32'(bc), 32'd10);
            @(posedge clk); #1 rst_n = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
            @(negedge clk);
            chk("t5_in_ready", 32'(in_ready), 32'd1);
            chk("t5_out_valid", 32'(out_valid), 32'd0);
            chk("t5_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
            run_block(t1, 0);
        end

        // Randomized blocks mixing full-range words, small values and signed zeros.
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 2))
                    0: rnd[k] = $urandom;
                    1: rnd[k] = pool[$urandom_range(0, 4)];
                    default: rnd[k] = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 4095))};
                endcase
            end
            run_block(rnd, (b % 3 == 2) ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
